obi_mem_arbiter: RTL

Two-requester round-robin arbiter that shares one OBI-style memory slave port between the core's instruction-fetch and data-access request streams. It sits between the core's native memory interfaces and a single-ported RAM or bridge. It tracks outstanding transactions in an in-order ID FIFO and routes each response back to the requester that issued it.

---
 rtl/obi_mem_arbiter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/obi_mem_arbiter.sv
// Round-robin arbiter sharing one OBI slave between instruction fetch (0) and data (1).
// An in-order ID FIFO remembers which requester owns each outstanding response.
module obi_mem_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic [1:0]                             req_i,
    input  logic [1:0][ADDR_WIDTH-1:0]             addr_i,
    input  logic [1:0]                             we_i,
    input  logic [1:0][DATA_WIDTH/8-1:0]           be_i,
    input  logic [1:0][DATA_WIDTH-1:0]             wdata_i,
    output logic [1:0]                             gnt_o,
    output logic [1:0]                             rvalid_o,
    output logic [1:0][DATA_WIDTH-1:0]             rdata_o,
    output logic                                   mem_req_o,
    input  logic                                   mem_gnt_i,
    output logic [ADDR_WIDTH-1:0]                  mem_addr_o,
    output logic                                   mem_we_o,
    output logic [DATA_WIDTH/8-1:0]                mem_be_o,
    output logic [DATA_WIDTH-1:0]                  mem_wdata_o,
    input  logic                                   mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]                  mem_rdata_i,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
    output logic                                   err_o
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic                       last_gnt_q, last_gnt_d;
    logic                       err_q, err_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic [PTR_W-1:0]           wptr_q, wptr_d;
    logic [PTR_W-1:0]           rptr_q, rptr_d;
    logic [MAX_OUTSTANDING-1:0] id_q, id_d;

    logic sel;
    logic full;
    logic empty;
    logic push;
    logic pop;
    logic head;

    always_comb begin
        sel = 1'b0;
        case (req_i)
            2'b10:   sel = 1'b1;
            2'b11:   sel = ~last_gnt_q;
            default: sel = 1'b0;
        endcase
    end

    assign full  = (count_q == CNT_W'(MAX_OUTSTANDING));
    assign empty = (count_q == '0);
    assign head  = id_q[rptr_q];

    // Full blocks requests outright so a same-cycle rvalid never feeds the grant path.
    assign mem_req_o = (|req_i) & ~full;
    assign push      = mem_req_o & mem_gnt_i;
    assign pop       = mem_rvalid_i & ~empty;

    always_comb begin
        mem_addr_o  = '0;
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_wdata_o = '0;
        gnt_o       = 2'b00;
        rvalid_o    = 2'b00;
        if (|req_i) begin
            mem_addr_o  = addr_i[sel];
            mem_we_o    = we_i[sel];
            mem_be_o    = be_i[sel];
            mem_wdata_o = wdata_i[sel];
        end
        gnt_o[sel]     = push;
        rvalid_o[head] = pop;
    end

    assign rdata_o       = {mem_rdata_i, mem_rdata_i};
    assign outstanding_o = count_q;
    assign err_o         = err_q;

    always_comb begin
        last_gnt_d = last_gnt_q;
        err_d      = err_q | (mem_rvalid_i & empty);
        count_d    = count_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        id_d       = id_q;
        if (push) begin
            last_gnt_d   = sel;
            id_d[wptr_q] = sel;
            wptr_d       = (wptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : wptr_q + PTR_W'(1);
        end
        if (pop) begin
            rptr_d = (rptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : rptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_gnt_q <= 1'b1;
            err_q      <= 1'b0;
            count_q    <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
        end else begin
            last_gnt_q <= last_gnt_d;
            err_q      <= err_d;
            count_q    <= count_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
        end
    end

    // ID storage is only meaningful under the pointers, so it needs no reset.
    always_ff @(posedge clk_i) begin
        id_q <= id_d;
    end

endmodule
